// File: rtl/serial_alu_ctrl_if.sv
// Host-side bundle for the bit-serial ALU: operation request plus completion status.
// Handshake: the host raises start with op/a/b valid; it is taken only while busy=0 and
// done=0 (IDLE). done pulses for exactly one cycle, and result/cout/zero hold until the next accepted start.
interface serial_alu_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result, cout, zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, cout, zero
  );
endinterface

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU sequencer: one full-adder cell plus AND/XOR is stepped WIDTH times,
// LSB first, and the carry is kept between steps. The result is reported with a one-cycle done pulse.
module serial_alu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_alu_ctrl_if.slave     bus,
  output logic [1:0]           o_dbg_state
);
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_sa;
  logic [WIDTH-1:0]   r_sb;
  logic [WIDTH-1:0]   r_acc;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_result;
  logic               r_cout;
  logic               r_zero;

  logic               w_last;
  logic               w_bit;
  logic               w_carry_nxt;
  logic [WIDTH-1:0]   w_acc_nxt;

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  // One step of the shared cell. SUB arrives here as a + ~b with a carry-in of 1.
  always_comb begin
    w_bit       = 1'b0;
    w_carry_nxt = 1'b0;
    case (r_op)
      OP_ADD, OP_SUB: begin
        w_bit       = r_sa[0] ^ r_sb[0] ^ r_carry;
        w_carry_nxt = (r_sa[0] & r_sb[0]) | (r_sa[0] & r_carry) | (r_sb[0] & r_carry);
      end
      OP_AND:  w_bit = r_sa[0] & r_sb[0];
      default: w_bit = r_sa[0] ^ r_sb[0];
    endcase
  end

  assign w_acc_nxt = {w_bit, r_acc[WIDTH-1:1]};

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op     <= OP_ADD;
      r_sa     <= '0;
      r_sb     <= '0;
      r_acc    <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_op    <= bus.op;
            r_sa    <= bus.a;
            r_sb    <= (bus.op == OP_SUB) ? ~bus.b : bus.b;
            r_carry <= (bus.op == OP_SUB);
            r_cnt   <= '0;
            r_acc   <= '0;
          end
        end
        RUN: begin
          r_acc   <= w_acc_nxt;
          r_sa    <= r_sa >> 1;
          r_sb    <= r_sb >> 1;
          r_carry <= w_carry_nxt;
          r_cnt   <= r_cnt + 1'b1;
          // Publish only on the final step so the outputs never show partial sums.
          if (w_last) begin
            r_result <= w_acc_nxt;
            r_cout   <= w_carry_nxt;
            r_zero   <= (w_acc_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (r_state == RUN);
  assign bus.done    = (r_state == DONE);
  assign bus.result  = r_result;
  assign bus.cout    = r_cout;
  assign bus.zero    = r_zero;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Directed test of serial_alu_ctrl at WIDTH=8: arithmetic/logic results, latency,
// start masking while busy, and asynchronous reset abort.
module tb_serial_alu_ctrl;
  localparam int WIDTH = 8;

  logic clk;
  logic rst;
  logic [1:0] dbg_state;
  int checks = 0;
  int errors = 0;

  serial_alu_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_alu_ctrl #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one op, then watches 12 cycles for busy length, done timing and results.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] exp_res,
                        input logic exp_cout, input logic exp_zero);
    int busy_cnt;
    int done_cnt;
    int done_cyc;
    busy_cnt = 0;
    done_cnt = 0;
    done_cyc = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        if (done_cnt == 0) done_cyc = c;
        done_cnt++;
      end
    end
    check({tag, "_busy_cycles"}, busy_cnt, 8);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_done_latency"}, done_cyc, 9);
    check({tag, "_result"}, bus.result, exp_res);
    check({tag, "_cout"}, bus.cout, exp_cout);
    check({tag, "_zero"}, bus.zero, exp_zero);
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    int done_cyc;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_result", bus.result, 0);
    check("reset_cout", bus.cout, 0);
    check("reset_zero", bus.zero, 0);
    check("reset_state", dbg_state, 0);
    rst = 1'b0;

    run_op("add_5a_3c", 2'b00, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b0);
    run_op("add_ff_01", 2'b00, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1);
    run_op("sub_10_20", 2'b01, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0);
    run_op("sub_20_20", 2'b01, 8'h20, 8'h20, 8'h00, 1'b1, 1'b1);
    run_op("and_f0_3c", 2'b10, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0);
    run_op("xor_f0_3c", 2'b11, 8'hF0, 8'h3C, 8'hCC, 1'b0, 1'b0);

    // ADD 1+2 with stray SUB 9-9 requests during RUN and during DONE.
    busy_cnt = 0;
    done_cnt = 0;
    done_cyc = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.a     = 8'h01;
    bus.b     = 8'h02;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        if (done_cnt == 0) done_cyc = c;
        done_cnt++;
      end
      if (c == 9) check("mask_state_done", dbg_state, 2);
      if (c == 2 || c == 9) begin
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.a     = 8'h09;
        bus.b     = 8'h09;
      end else begin
        bus.start = 1'b0;
      end
    end
    check("mask_busy_cycles", busy_cnt, 8);
    check("mask_done_count", done_cnt, 1);
    check("mask_done_latency", done_cyc, 9);
    check("mask_result", bus.result, 8'h03);
    check("mask_cout", bus.cout, 0);
    check("mask_idle_after", dbg_state, 0);
    run_op("sub_09_09", 2'b01, 8'h09, 8'h09, 8'h00, 1'b1, 1'b1);

    // Leave a non-zero result behind so the reset clear is visible.
    run_op("add_pre_rst", 2'b00, 8'h5A, 8'hC0, 8'h1A, 1'b1, 1'b0);

    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.a     = 8'h33;
    bus.b     = 8'h44;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_before", bus.busy, 1);
    rst = 1'b1;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_result", bus.result, 0);
    check("abort_cout", bus.cout, 0);
    check("abort_zero", bus.zero, 0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);
    check("abort_state_idle", dbg_state, 0);
    run_op("add_07_08", 2'b00, 8'h07, 8'h08, 8'h0F, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
